// File: rtl/traffic_analyzer_capture_ctrl.sv
// rtl/traffic_analyzer_capture_ctrl.sv - measurement sequencer aligning analyzer run/freeze to GMII frame boundaries
module traffic_analyzer_capture_ctrl #(
    parameter int C_CNT_WIDTH    = 32,
    parameter int C_WINDOW_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                cfg_mode,
    input  logic [C_CNT_WIDTH-1:0]    cfg_frames,
    input  logic [C_WINDOW_WIDTH-1:0] cfg_window,
    input  logic                      arm,
    input  logic                      abort,
    input  logic                      gmii_en,
    output logic                      ctrl_run,
    output logic                      ctrl_freeze,
    output logic                      busy,
    output logic                      done,
    output logic [C_CNT_WIDTH-1:0]    frames_seen,
    output logic [C_WINDOW_WIDTH-1:0] cycles_elapsed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_GAP,
        S_ACTIVE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_CONT   = 2'd0;
    localparam logic [1:0] MODE_FRAMES = 2'd1;
    localparam logic [1:0] MODE_WINDOW = 2'd2;

    localparam logic [C_CNT_WIDTH-1:0]    CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_WINDOW_WIDTH-1:0] WIN_ONE = {{(C_WINDOW_WIDTH-1){1'b0}}, 1'b1};

    state_t                      state_q;
    state_t                      state_d;
    logic [1:0]                  mode_q;
    logic [C_CNT_WIDTH-1:0]      frames_lim_q;
    logic [C_WINDOW_WIDTH-1:0]   window_lim_q;
    logic                        gmii_en_d;
    logic                        sof;
    logic                        eof;
    logic                        start;
    logic                        zero_limit;
    logic                        window_last;

    assign sof = gmii_en & ~gmii_en_d;
    assign eof = ~gmii_en & gmii_en_d;

    // A zero limit must never open the analyzer, so WAIT_GAP skips straight to DONE.
    assign zero_limit = ((mode_q == MODE_FRAMES) && (frames_lim_q == '0)) ||
                        ((mode_q == MODE_WINDOW) && (window_lim_q == '0));
    assign window_last = (cycles_elapsed == (window_lim_q - WIN_ONE));

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    start   = 1'b1;
                    state_d = S_WAIT_GAP;
                end
            end
            S_WAIT_GAP: begin
                if (!gmii_en) begin
                    state_d = zero_limit ? S_DONE : S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                case (mode_q)
                    MODE_FRAMES: begin
                        if (eof && (frames_seen == frames_lim_q)) begin
                            state_d = S_DONE;
                        end
                    end
                    MODE_WINDOW: begin
                        if (window_last) begin
                            state_d = gmii_en ? S_DRAIN : S_DONE;
                        end
                    end
                    default: ;
                endcase
            end
            S_DRAIN: begin
                if (!gmii_en) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (arm) begin
                    start   = 1'b1;
                    state_d = S_WAIT_GAP;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            start   = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            mode_q         <= MODE_CONT;
            frames_lim_q   <= '0;
            window_lim_q   <= '0;
            gmii_en_d      <= 1'b0;
            frames_seen    <= '0;
            cycles_elapsed <= '0;
            ctrl_run       <= 1'b0;
            ctrl_freeze    <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q   <= state_d;
            gmii_en_d <= gmii_en;
            if (start) begin
                mode_q         <= (cfg_mode == 2'd3) ? MODE_CONT : cfg_mode;
                frames_lim_q   <= cfg_frames;
                window_lim_q   <= cfg_window;
                frames_seen    <= '0;
                cycles_elapsed <= '0;
            end else if ((state_q == S_ACTIVE) && !abort) begin
                if (cycles_elapsed != '1) begin
                    cycles_elapsed <= cycles_elapsed + WIN_ONE;
                end
                if (sof && (frames_seen != '1)) begin
                    frames_seen <= frames_seen + CNT_ONE;
                end
            end
            // Outputs decode the state being entered so they line up with state_q.
            ctrl_run    <= (state_d == S_ACTIVE) || (state_d == S_DRAIN);
            ctrl_freeze <= !((state_d == S_ACTIVE) || (state_d == S_DRAIN));
            busy        <= (state_d == S_WAIT_GAP) || (state_d == S_ACTIVE) ||
                           (state_d == S_DRAIN);
            done        <= (state_d == S_DONE);
        end
    end

endmodule

// File: doc/traffic_analyzer_capture_ctrl.md
Name: traffic_analyzer_capture_ctrl

Overview:
Measurement sequencer for the traffic_analyzer_gmii datapath. It drives the analyzer's run and freeze_stats control bits so that each measurement opens and closes at GMII frame boundaries. Three modes are supported: continuous, stop after N frames, and stop after a fixed window of clock cycles. It sits in the GMII clock domain between the CPU-facing configuration and the analyzer's control inputs, and exposes progress counters for software.

Parameters:
C_CNT_WIDTH, 32, width of frame-count limit and frames_seen counter
C_WINDOW_WIDTH, 32, width of cycle-window limit and cycles_elapsed counter

Ports:
clk  in  1  GMII-domain clock, same as the analyzer clock
rst  in  1  synchronous, active-high reset
cfg_mode  in  2  0=continuous, 1=frame count, 2=time window, 3=reserved (treated as 0)
cfg_frames  in  C_CNT_WIDTH  frame limit for mode 1
cfg_window  in  C_WINDOW_WIDTH  cycle limit for mode 2
arm  in  1  single-cycle pulse that starts a measurement
abort  in  1  single-cycle pulse that stops immediately and returns to IDLE
gmii_en  in  1  GMII enable from the monitored link; marks frame boundaries
ctrl_run  out  1  drives analyzer control bit 0
ctrl_freeze  out  1  drives analyzer control bit 1
busy  out  1  high in WAIT_GAP, ACTIVE and DRAIN
done  out  1  high in DONE
frames_seen  out  C_CNT_WIDTH  frame starts counted in the current measurement
cycles_elapsed  out  C_WINDOW_WIDTH  clk cycles spent in ACTIVE

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high (rst), sampled on the clk rising edge.
- Registered outputs: all outputs are registered. Each output reflects the state entered on the same edge, so there is one cycle of latency from an input to the output.
- Reset values: state=IDLE, ctrl_run=0, ctrl_freeze=1, busy=0, done=0, frames_seen=0, cycles_elapsed=0, gmii_en_d=0.
- Edge detection: gmii_en_d is gmii_en delayed by one cycle. A frame start (sof) is gmii_en & ~gmii_en_d. A frame end (eof) is ~gmii_en & gmii_en_d.
- Output decode per state: IDLE gives run=0, freeze=1. WAIT_GAP gives run=0, freeze=1. ACTIVE and DRAIN give run=1, freeze=0. DONE gives run=0, freeze=1.
- IDLE:
  - On arm, latch cfg_mode, cfg_frames and cfg_window into shadow registers.
  - Clear frames_seen and cycles_elapsed.
  - Go to WAIT_GAP.
  - Config inputs are ignored outside this arm edge.
- WAIT_GAP:
  - If gmii_en==0, go to ACTIVE. This guarantees the first counted frame is whole.
  - If a frame is in progress, stay until gmii_en drops.
  - Mode 1 with limit 0, or mode 2 with limit 0: go directly to DONE instead of ACTIVE.
- ACTIVE:
  - cycles_elapsed increments every cycle.
  - frames_seen increments on each sof.
  - Both counters saturate at all-ones and never wrap.
  - Mode 0: remain in ACTIVE until abort.
  - Mode 1: on the eof that occurs while frames_seen==cfg_frames, go to DONE. Frames starting after the Nth are not counted because the state has already left ACTIVE.
  - Mode 2: when cycles_elapsed==cfg_window-1, go to DRAIN (window of exactly cfg_window ACTIVE cycles). If gmii_en==0 on that same cycle, go straight to DONE.
- DRAIN: counters hold. sof is not counted. Go to DONE on the first cycle with gmii_en==0.
- DONE:
  - done=1. Counters are held for software readout.
  - arm re-latches config, clears counters and goes to WAIT_GAP.
  - abort goes to IDLE.
- Priority: rst > abort > arm > state logic.
  - abort in any state goes to IDLE on the next cycle. Counters hold their values and are not cleared.
  - arm while busy is ignored.
  - arm and abort in the same cycle give IDLE.
- Reset mid-measurement: returns to IDLE with ctrl_freeze=1 on the next edge, regardless of gmii_en.

Test Plan:
- Reset, then idle: after rst, ctrl_run=0, ctrl_freeze=1, busy=0, done=0, both counters 0, held for 10 cycles.
- Mode 1 with cfg_frames=3 and five 64-byte frames with 12-cycle gaps: arm in a gap; busy=1 for 1 cycle, then ctrl_run=1. frames_seen=3. done=1 one cycle after the 3rd frame's eof. Frames 4 and 5 are not counted.
- Arm during a frame (mode 1, cfg_frames=2, arm on byte 10 of a 100-byte frame): state stays in WAIT_GAP with ctrl_run=0 until the frame ends. That frame is not counted, and the next two frames give frames_seen=2, done=1.
- Mode 2 with cfg_window=100 and continuous 1500-byte frames: ctrl_freeze falls, and cycles_elapsed=100 when DRAIN is entered. ctrl_freeze returns to 1 only after the current frame's eof, and done=1.
- Mode 2 window edges:
  - cfg_window=0: done=1 directly after WAIT_GAP, cycles_elapsed=0.
  - cfg_window=1 with gmii_en=0: exactly one ACTIVE cycle, then DONE.
- Abort and conflicts:
  - abort in ACTIVE in mode 0 after 50 cycles: IDLE next cycle, cycles_elapsed=50 held, ctrl_freeze=1.
  - arm and abort in the same cycle: IDLE.
  - rst in DRAIN: IDLE, all outputs at reset values.
